// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port RAM access controller for a simple CPU handshake.
// A request is taken only in IDLE. Writes strobe mem_write for one cycle.
// Reads hold mem_read for RD_LAT cycles and capture mem_dout into cpu_rdata
// at the edge that ends the last read cycle. cpu_ack pulses for one cycle.
// Optional build: define MEM_ADDR_CHECK_EN to reject CPU addresses whose bits
// above ADDR_W are nonzero. Such requests go through an ERR state that pulses
// cpu_err together with cpu_ack and issues no RAM strobe. When the macro is
// not defined, the upper address bits are dropped and cpu_err stays 0.
module mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_busy,
  output logic              cpu_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

`ifdef MEM_ADDR_CHECK_EN
  typedef enum logic [2:0] {IDLE, WR, RD, ACK, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;
`endif

  // A 2-bit counter covers up to four read cycles.
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  rd_cnt_reg, rd_cnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              accept;
  logic              rd_last;

  // A request counts only when the controller is idle.
  // While busy, all CPU inputs are ignored.
  assign accept  = (state_reg == IDLE) && cpu_req;
  assign rd_last = (rd_cnt_reg == RD_LAST);

`ifdef MEM_ADDR_CHECK_EN
  logic addr_bad;
  assign addr_bad = |cpu_addr[31:ADDR_W];
`else
  // The upper address bits are intentionally dropped in this build.
  logic addr_hi_unused;
  assign addr_hi_unused = ^cpu_addr[31:ADDR_W];
`endif

  // State register and read-cycle counter.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg  <= IDLE;
      rd_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rd_cnt_reg <= rd_cnt_next;
    end
  end

  // Next-state logic. The read counter restarts on every acceptance.
  always_comb begin
    state_next  = state_reg;
    rd_cnt_next = rd_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_req) begin
          rd_cnt_next = '0;
`ifdef MEM_ADDR_CHECK_EN
          if (addr_bad) begin
            state_next = ERR;
          end else begin
            state_next = cpu_we ? WR : RD;
          end
`else
          state_next = cpu_we ? WR : RD;
`endif
        end
      end
      WR: begin
        state_next = ACK;
      end
      RD: begin
        if (rd_last) begin
          state_next = ACK;
        end else begin
          rd_cnt_next = rd_cnt_reg + CNT_W'(1);
        end
      end
      ACK: begin
        state_next = IDLE;
      end
`ifdef MEM_ADDR_CHECK_EN
      ERR: begin
        state_next = IDLE;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the address and write data at acceptance.
  // The RAM sees these values unchanged until the next acceptance.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      addr_reg  <= cpu_addr[ADDR_W-1:0];
      wdata_reg <= cpu_wdata;
    end
  end

  // Memory data register.
  // It is loaded only at the edge that ends the last read cycle.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      rdata_reg <= '0;
    end else if ((state_reg == RD) && rd_last) begin
      rdata_reg <= mem_dout;
    end
  end

  // Output decode straight from the state register.
  // As a result, reset clears every output at once.
  always_comb begin
    cpu_busy  = (state_reg != IDLE);
    mem_write = (state_reg == WR);
    mem_read  = (state_reg == RD);
`ifdef MEM_ADDR_CHECK_EN
    cpu_ack   = (state_reg == ACK) || (state_reg == ERR);
    cpu_err   = (state_reg == ERR);
`else
    cpu_ack   = (state_reg == ACK);
    cpu_err   = 1'b0;
`endif
  end

  assign cpu_rdata = rdata_reg;
  assign mem_addr  = addr_reg;
  assign mem_din   = wdata_reg;

endmodule
